// File: rtl/ips2l_pcie_seio_pkg.sv
// Shared state encoding, default parameters and helpers for the SEIO arbiter.
package ips2l_pcie_seio_pkg;

    localparam int unsigned DefNReq   = 2;
    localparam int unsigned DefAddrW  = 12;
    localparam int unsigned DefDataW  = 8;
    localparam int unsigned DefAckTmo = 255;

    // Width of the frame/read-data bit counter.
    localparam int unsigned CntW = 5;

    typedef enum logic [2:0] {
        StIdle,
        StPre0,
        StPre1,
        StShift,
        StStop,
        StWaitAck,
        StRdata,
        StDone
    } seio_state_e;

    // Index following idx in a ring of n requesters; becomes the new top priority.
    function automatic logic [1:0] rr_next(input logic [1:0] idx, input int unsigned n);
        return (32'(idx) + 32'd1 >= n) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/ips2l_pcie_seio_rr_arb.sv
// Round-robin grant: the first active request at or after ptr_i wins.
module ips2l_pcie_seio_rr_arb
    import ips2l_pcie_seio_pkg::*;
#(
    parameter int unsigned N_REQ = DefNReq
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [1:0]       ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [1:0]       idx_o,
    output logic             vld_o
);

    // Walk the ring starting at the pointer and stop at the first requester.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!vld_o && req_i[i] && ((32'(ptr_i) + k) % N_REQ == i)) begin
                    vld_o    = 1'b1;
                    gnt_o[i] = 1'b1;
                    idx_o    = 2'(i);
                end
            end
        end
    end

endmodule

// File: rtl/ips2l_pcie_seio_arb.sv
// SEIO command arbiter: grants one requester at a time and runs a serial
// frame (preamble, address, optional write data) followed by ack/read-back.
module ips2l_pcie_seio_arb
    import ips2l_pcie_seio_pkg::*;
#(
    parameter int unsigned N_REQ   = DefNReq,
    parameter int unsigned ADDR_W  = DefAddrW,
    parameter int unsigned DATA_W  = DefDataW,
    parameter int unsigned ACK_TMO = DefAckTmo
) (
    input  logic                      pclk_div2,
    input  logic                      user_rst,
    input  logic [N_REQ-1:0]          req_vld,
    input  logic [N_REQ-1:0]          req_wr,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_rdy,
    output logic                      rsp_vld,
    output logic [1:0]                rsp_id,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      sedo,
    output logic                      sedo_en,
    input  logic                      sedi,
    input  logic                      sedi_ack,
    output logic                      busy
);

    localparam int unsigned FrameW = ADDR_W + DATA_W;
    localparam int unsigned TmoW   = $clog2(ACK_TMO + 2);

    seio_state_e         state_q;
    logic [1:0]          ptr_q;
    logic [1:0]          id_q;
    logic                wr_q;
    logic [FrameW-1:0]   sh_q;
    logic [CntW-1:0]     cnt_q;
    logic [TmoW-1:0]     tmo_q;

    logic [N_REQ-1:0]    gnt;
    logic [1:0]          gnt_idx;
    logic                gnt_vld;
    logic                sel_wr;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [CntW-1:0]     last_bit;

    ips2l_pcie_seio_rr_arb #(
        .N_REQ (N_REQ)
    ) u_rr_arb (
        .req_i (req_vld),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .vld_o (gnt_vld)
    );

    // Pick the granted requester's command fields.
    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_wr    = req_wr[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Reads stop after the address; writes carry the data bits too.
    always_comb begin
        last_bit = wr_q ? CntW'(FrameW - 1) : CntW'(ADDR_W - 1);
    end

    // Frame sequencer with registered outputs aligned to the current state.
    always_ff @(posedge pclk_div2 or posedge user_rst) begin
        if (user_rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            id_q      <= '0;
            wr_q      <= 1'b0;
            sh_q      <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            req_rdy   <= '0;
            rsp_vld   <= 1'b0;
            rsp_id    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            sedo      <= 1'b0;
            sedo_en   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            req_rdy <= '0;
            rsp_vld <= 1'b0;
            rsp_err <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (gnt_vld) begin
                        req_rdy   <= gnt;
                        id_q      <= gnt_idx;
                        ptr_q     <= rr_next(gnt_idx, N_REQ);
                        wr_q      <= sel_wr;
                        sh_q      <= {sel_addr, sel_wdata};
                        rsp_rdata <= '0;
                        sedo_en   <= 1'b1;
                        sedo      <= ~sel_wr;
                        busy      <= 1'b1;
                        state_q   <= StPre0;
                    end
                end
                StPre0: begin
                    sedo    <= wr_q;
                    state_q <= StPre1;
                end
                StPre1: begin
                    sedo    <= sh_q[FrameW-1];
                    sh_q    <= sh_q << 1;
                    cnt_q   <= '0;
                    state_q <= StShift;
                end
                StShift: begin
                    if (cnt_q == last_bit) begin
                        sedo    <= 1'b0;
                        sedo_en <= 1'b0;
                        state_q <= StStop;
                    end else begin
                        sedo  <= sh_q[FrameW-1];
                        sh_q  <= sh_q << 1;
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StStop: begin
                    tmo_q   <= '0;
                    state_q <= StWaitAck;
                end
                StWaitAck: begin
                    if (sedi_ack) begin
                        cnt_q <= '0;
                        if (wr_q) begin
                            rsp_vld <= 1'b1;
                            rsp_id  <= id_q;
                            state_q <= StDone;
                        end else begin
                            state_q <= StRdata;
                        end
                    end else if (tmo_q == TmoW'(ACK_TMO)) begin
                        rsp_vld <= 1'b1;
                        rsp_id  <= id_q;
                        rsp_err <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end
                StRdata: begin
                    rsp_rdata <= {rsp_rdata[DATA_W-2:0], sedi};
                    if (cnt_q == CntW'(DATA_W - 1)) begin
                        rsp_vld <= 1'b1;
                        rsp_id  <= id_q;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    sedo    <= 1'b0;
                    sedo_en <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ips2l_pcie_seio_arb.sv
// Self-checking bench for ips2l_pcie_seio_arb: directed and random transactions
// against a frame-level model of the serial protocol and round-robin grant.
module tb_ips2l_pcie_seio_arb;

    localparam int N_REQ   = 2;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 8;
    localparam int ACK_TMO = 255;

    logic                    clk = 1'b0;
    logic                    user_rst;
    logic [N_REQ-1:0]        req_vld;
    logic [N_REQ-1:0]        req_wr;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        req_rdy;
    logic                    rsp_vld;
    logic [1:0]              rsp_id;
    logic [DATA_W-1:0]       rsp_rdata;
    logic                    rsp_err;
    logic                    sedo;
    logic                    sedo_en;
    logic                    sedi;
    logic                    sedi_ack;
    logic                    busy;

    int errors = 0;
    int checks = 0;
    int ptr_m  = 0;  // model: index with highest priority for the next grant

    always #5 clk = ~clk;

    ips2l_pcie_seio_arb #(
        .N_REQ   (N_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .ACK_TMO (ACK_TMO)
    ) dut (
        .pclk_div2 (clk),
        .user_rst  (user_rst),
        .req_vld   (req_vld),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_rdy   (req_rdy),
        .rsp_vld   (rsp_vld),
        .rsp_id    (rsp_id),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .sedo      (sedo),
        .sedo_en   (sedo_en),
        .sedi      (sedi),
        .sedi_ack  (sedi_ack),
        .busy      (busy)
    );

    function automatic int model_grant(input logic [N_REQ-1:0] req, input int ptr);
        for (int k = 0; k < N_REQ; k++) begin
            int c;
            c = (ptr + k) % N_REQ;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input bit wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        req_wr[i]                   = wr;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    // Runs one transaction with req_vld already driven; ack_dly < 0 means no ack.
    task automatic run_txn(input int ack_dly, input logic [DATA_W-1:0] slave_rd,
                           input bit drop, input bit spur);
        int                g, cyc, idx, exp_idx;
        bit                wr, frame_ok, side_ok, seen;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d, exp_rd;
        logic [N_REQ-1:0]  exp_rdy;
        logic              exp_bits[$];
        logic              got_bits[$];

        g = model_grant(req_vld, ptr_m);
        if (g < 0) g = 0;
        wr = req_wr[g];
        a  = req_addr[g*ADDR_W +: ADDR_W];
        d  = req_wdata[g*DATA_W +: DATA_W];
        exp_rdy    = '0;
        exp_rdy[g] = 1'b1;

        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (req_rdy === '0 && cyc < 8);
        checks++;
        if (req_rdy !== exp_rdy) begin
            errors++;
            $display("FAIL grant: req_rdy=%b required %b", req_rdy, exp_rdy);
            if (req_rdy === '0) return;
        end
        ptr_m = (g + 1) % N_REQ;
        if (drop) req_vld[g] = 1'b0;

        exp_bits.push_back(!wr);
        exp_bits.push_back(wr);
        for (int i = ADDR_W - 1; i >= 0; i--) exp_bits.push_back(a[i]);
        if (wr) for (int i = DATA_W - 1; i >= 0; i--) exp_bits.push_back(d[i]);

        side_ok = 1'b1;
        cyc = 0;
        while (sedo_en === 1'b1 && cyc < 40) begin
            got_bits.push_back(sedo);
            if (busy !== 1'b1 || rsp_vld !== 1'b0) side_ok = 1'b0;
            if (cyc == 1 && req_rdy !== '0) side_ok = 1'b0;
            sedi_ack = spur && (cyc == 6);
            @(negedge clk);
            cyc++;
        end
        sedi_ack = 1'b0;

        frame_ok = (got_bits.size() == exp_bits.size());
        if (frame_ok)
            for (int i = 0; i < exp_bits.size(); i++)
                if (got_bits[i] !== exp_bits[i]) frame_ok = 1'b0;
        checks++;
        if (!frame_ok) begin
            errors++;
            $display("FAIL frame: id=%0d sedo_en cycles=%0d required %0d or bit error",
                     g, got_bits.size(), exp_bits.size());
        end
        checks++;
        if (!side_ok || sedo !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_side: side_ok=%0d sedo=%b busy=%b required 1,0,1",
                     side_ok, sedo, busy);
        end

        @(negedge clk);  // first WAIT_ACK cycle
        idx  = 0;
        seen = 1'b0;
        side_ok = 1'b1;
        while (!seen && idx < 400) begin
            sedi_ack = (idx == ack_dly);
            if (ack_dly >= 0 && idx > ack_dly && idx <= ack_dly + DATA_W)
                sedi = slave_rd[DATA_W + ack_dly - idx];
            else
                sedi = 1'($urandom);
            if (sedo_en !== 1'b0 || sedo !== 1'b0) side_ok = 1'b0;
            @(negedge clk);
            idx++;
            if (rsp_vld === 1'b1) seen = 1'b1;
        end
        sedi_ack = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: no rsp_vld within %0d cycles", idx);
            return;
        end

        if (ack_dly < 0) exp_idx = ACK_TMO + 1;
        else if (wr)     exp_idx = ack_dly + 1;
        else             exp_idx = ack_dly + 1 + DATA_W;
        exp_rd = (!wr && ack_dly >= 0) ? slave_rd : '0;

        checks++;
        if (idx != exp_idx || !side_ok) begin
            errors++;
            $display("FAIL rsp_latency: cycles=%0d idle_ok=%0d required %0d,1",
                     idx, side_ok, exp_idx);
        end
        checks++;
        if (rsp_id !== 2'(g) || rsp_err !== (ack_dly < 0) || rsp_rdata !== exp_rd) begin
            errors++;
            $display("FAIL rsp_fields: id=%0d err=%b rdata=%h required %0d %b %h",
                     rsp_id, rsp_err, rsp_rdata, g, (ack_dly < 0), exp_rd);
        end

        @(negedge clk);  // mandatory idle gap
        checks++;
        if (rsp_vld !== 1'b0 || busy !== 1'b0 || req_rdy !== '0) begin
            errors++;
            $display("FAIL idle_gap: rsp_vld=%b busy=%b req_rdy=%b required 0,0,0",
                     rsp_vld, busy, req_rdy);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (sedo_en !== 1'b0 || sedo !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_serial: sedo_en=%b sedo=%b busy=%b required 0", sedo_en, sedo, busy);
        end
        checks++;
        if (req_rdy !== '0 || rsp_vld !== 1'b0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: req_rdy=%b rsp_vld=%b rsp_err=%b required 0",
                     req_rdy, rsp_vld, rsp_err);
        end
        checks++;
        if (rsp_id !== 2'd0 || rsp_rdata !== '0) begin
            errors++;
            $display("FAIL reset_rsp: rsp_id=%0d rsp_rdata=%h required 0", rsp_id, rsp_rdata);
        end
        user_rst = 1'b0;
        ptr_m    = 0;
        @(negedge clk);
    endtask

    task automatic test_write_directed();
        set_req(0, 1'b1, 12'h0A5, 8'h3C);
        req_vld = 2'b01;
        run_txn(4, 8'h00, 1'b0, 1'b0);
        req_vld = '0;
    endtask

    task automatic test_read_directed();
        set_req(1, 1'b0, 12'hFFF, 8'h00);
        req_vld = 2'b10;
        run_txn(2, 8'h81, 1'b1, 1'b0);
        req_vld = '0;
    endtask

    task automatic test_spurious_ack();
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sedi_ack = 1'b1;
            @(negedge clk);
            if (rsp_vld !== 1'b0 || busy !== 1'b0 || sedo_en !== 1'b0) bad = 1'b1;
        end
        sedi_ack = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL spurious_idle: activity seen in IDLE, required none");
        end
        set_req(0, 1'b1, 12'($urandom), 8'($urandom));
        req_vld = 2'b01;
        run_txn(3, 8'h00, 1'b0, 1'b1);
        req_vld = '0;
    endtask

    task automatic test_alternate();
        req_vld = 2'b11;
        for (int t = 0; t < 4; t++) begin
            set_req(0, 1'($urandom), 12'($urandom), 8'($urandom));
            set_req(1, 1'($urandom), 12'($urandom), 8'($urandom));
            run_txn(int'($urandom_range(0, 5)), 8'($urandom), 1'b0, 1'b0);
        end
        req_vld = '0;
    endtask

    task automatic test_timeout();
        set_req(1, 1'b0, 12'h123, 8'h00);
        req_vld = 2'b10;
        run_txn(-1, 8'hFF, 1'b1, 1'b0);
        req_vld = '0;
    endtask

    task automatic test_reset_mid_frame();
        int cyc;
        bit bad;
        set_req(0, 1'b1, 12'($urandom), 8'($urandom));
        set_req(1, 1'b0, 12'($urandom), 8'($urandom));
        req_vld = 2'b01;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (req_rdy === '0 && cyc < 8);
        req_vld = '0;
        repeat (4) @(negedge clk);
        checks++;
        if (sedo_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_frame: sedo_en=%b required 1 before reset", sedo_en);
        end
        user_rst = 1'b1;
        #1;
        checks++;
        if (sedo_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: sedo_en=%b busy=%b required 0,0", sedo_en, busy);
        end
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_vld !== 1'b0 || sedo_en !== 1'b0) bad = 1'b1;
        end
        user_rst = 1'b0;
        ptr_m    = 0;
        @(negedge clk);
        if (rsp_vld !== 1'b0) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_abandon: rsp_vld or sedo_en seen after reset, required 0");
        end
        req_vld = 2'b11;
        run_txn(1, 8'($urandom), 1'b1, 1'b0);
        req_vld = '0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 14; t++) begin
            int dly;
            logic [N_REQ-1:0] v;
            v = N_REQ'($urandom_range(1, 3));
            set_req(0, 1'($urandom), 12'($urandom), 8'($urandom));
            set_req(1, 1'($urandom), 12'($urandom), 8'($urandom));
            dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
            req_vld = v;
            run_txn(dly, 8'($urandom), 1'($urandom), 1'($urandom));
        end
        req_vld = '0;
    endtask

    initial begin
        user_rst  = 1'b1;
        req_vld   = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        sedi      = 1'b0;
        sedi_ack  = 1'b0;
        test_reset();
        test_write_directed();
        test_read_directed();
        test_spurious_ack();
        test_alternate();
        test_timeout();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ips2l_pcie_seio_arb.md
IPS2L_PCIE_SEIO_ARB -- requirements
Module: ips2l_pcie_seio_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of requesters (legal 2..4).
REQ-002 SHALL have parameter ADDR_W, default 12, SEIO register address width.
REQ-003 SHALL have parameter DATA_W, default 8, SEIO data width.
REQ-004 SHALL have parameter ACK_TMO, default 255, cycles to wait for sedi_ack before error.
REQ-005 SHALL have port pclk_div2  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port user_rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port req_vld  input  N_REQ  per-requester transaction request.
REQ-008 SHALL have port req_wr  input  N_REQ  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  N_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port req_wdata  input  N_REQ*DATA_W  flattened write data.
REQ-011 SHALL have port req_rdy  output  N_REQ  one-hot accept pulse.
REQ-012 SHALL have port rsp_vld  output  1  one-cycle completion pulse.
REQ-013 SHALL have port rsp_id  output  2  index of completed requester.
REQ-014 SHALL have port rsp_rdata  output  DATA_W  read data, valid with rsp_vld.
REQ-015 SHALL have port rsp_err  output  1  ack timeout, valid with rsp_vld.
REQ-016 SHALL have ports sedo  output  1, sedo_en  output  1  serial command to SEIO slave.
REQ-017 SHALL have ports sedi  input  1, sedi_ack  input  1  serial read data and ack pulse from slave.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-019 SHALL implement states IDLE, PRE0, PRE1, SHIFT, STOP, WAIT_ACK, RDATA, DONE.
REQ-020 IDLE: if any req_vld, grant round-robin (priority starts after last granted index; after reset index 0 highest), pulse req_rdy[g] for one cycle, latch wr/addr/wdata, go PRE0.
REQ-021 PRE0: sedo_en=1, sedo=~wr; PRE1: sedo_en=1, sedo=wr (write = rising edge on sedo, read = falling edge).
REQ-022 SHIFT: sedo_en=1; shift address MSB first for ADDR_W cycles, then for writes only DATA_W data bits MSB first; 5-bit bit counter, no wrap beyond frame length.
REQ-023 STOP: sedo_en=0, sedo=0 for 1 cycle, then WAIT_ACK with timeout counter cleared.
REQ-024 WAIT_ACK: on sedi_ack go RDATA if read, DONE if write; after ACK_TMO cycles without ack go DONE with error flag set.
REQ-025 RDATA: sample sedi for DATA_W cycles starting the cycle after the ack, MSB first, into rsp_rdata.
REQ-026 DONE: pulse rsp_vld for one cycle with rsp_id, rsp_rdata (0 for writes and timeouts), rsp_err; return to IDLE.
REQ-027 Outside PRE0/PRE1/SHIFT, sedo and sedo_en SHALL be 0.
REQ-028 sedi_ack outside WAIT_ACK SHALL be ignored.
REQ-029 New grant SHALL not occur until the cycle after DONE; minimum gap between frames is 1 IDLE cycle.
REQ-030 req_vld deasserted after grant SHALL not abort the transaction.

Reset
REQ-031 On user_rst high, immediately: state IDLE, sedo=0, sedo_en=0, req_rdy=0, rsp_vld=0, rsp_id=0, rsp_rdata=0, rsp_err=0, busy=0, round-robin pointer=0, counters=0.
REQ-032 Reset mid-frame SHALL abandon the transaction with no rsp_vld; sedo_en drops to 0 asynchronously.

Structure
REQ-033 State encoding and default parameter values SHALL live in shared package ips2l_pcie_seio_pkg.
REQ-034 Round-robin grant logic SHALL be sub-module ips2l_pcie_seio_rr_arb (req vector, pointer -> one-hot grant, index).

Verification
REQ-035 Write req0 addr 0x0A5, wdata 0x3C -> sedo sequence 0,1 then 000010100101 then 00111100, sedo_en high 22 cycles; ack after 4 cycles -> rsp_vld, rsp_id=0, rsp_err=0.
REQ-036 Read req1 addr 0xFFF, slave drives sedi 0x81 after ack -> sedo 1,0, 12 ones, sedo_en high 14 cycles; rsp_rdata=0x81, rsp_id=1.
REQ-037 req0 and req1 asserted continuously -> grants alternate 0,1,0,1; each req_rdy one-hot single-cycle.
REQ-038 No sedi_ack -> rsp_vld with rsp_err=1, rsp_rdata=0 exactly ACK_TMO+1 cycles after entering WAIT_ACK.
REQ-039 user_rst asserted during SHIFT -> sedo_en=0 same cycle, no rsp_vld, next request starts cleanly from PRE0 with grant to requester 0.
REQ-040 Spurious sedi_ack during IDLE and SHIFT -> no state change, no rsp_vld.
